// File: rtl/pe_tile_scheduler.sv
// Tile sequencer for the 16-in x 4-out PE array. It walks every (cout group, cin group) pair:
// it fetches a weight block, then streams tile_size+1 pixels through the array and drains the pipeline.
module pe_tile_scheduler #(
    parameter int AW = 16,
    parameter int GW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [15:0]   cfg_tile_size,
    input  logic [GW-1:0] cfg_n_cin,
    input  logic [GW-1:0] cfg_n_cout,
    input  logic [AW-1:0] cfg_pb_base,
    output logic          w_req,
    output logic [AW-1:0] w_addr,
    input  logic          w_ack,
    output logic          dr_en,
    output logic [AW-1:0] dr_addr,
    output logic [2:0]    top_level_state,
    output logic [AW-1:0] pb_addr,
    output logic          new_tile,
    output logic [15:0]   tile_size,
    input  logic          pe_finish_flg,
    output logic          busy,
    output logic          done,
    output logic          err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRIME = 3'd1,
        S_LOADW = 3'd2,
        S_CALC  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t        state, state_n;
    logic [16:0]   cnt, cnt_n;
    logic [GW-1:0] cin_g, cin_g_n, cout_g, cout_g_n;
    logic [GW-1:0] n_cin, n_cin_n, n_cout, n_cout_n;
    logic [AW-1:0] d_off, d_off_n, p_off, p_off_n;
    logic [AW-1:0] blk, blk_n, pb_base, pb_base_n;
    logic [15:0]   tile_size_n;
    logic          err_n;

    logic          w_req_n, dr_en_n, new_tile_n;
    logic [AW-1:0] w_addr_n, dr_addr_n, pb_addr_n;

    logic [16:0]   calc_last;
    logic [AW-1:0] t_step;
    logic          at_last;

    // The CALC count runs one bit wider than tile_size so tile_size+3 never wraps.
    assign calc_last = {1'b0, tile_size} + 17'd3;
    assign t_step    = AW'({1'b0, tile_size} + 17'd1);
    assign at_last   = (cnt == calc_last);

    assign top_level_state = state;
    assign busy            = (state != S_IDLE);
    assign done            = (state == S_DONE);

    // NOTE: every variable gets its default before the case; a missed branch would otherwise infer a latch.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        cin_g_n     = cin_g;
        cout_g_n    = cout_g;
        n_cin_n     = n_cin;
        n_cout_n    = n_cout;
        d_off_n     = d_off;
        p_off_n     = p_off;
        blk_n       = blk;
        pb_base_n   = pb_base;
        tile_size_n = tile_size;
        err_n       = err;

        unique case (state)
            S_IDLE: begin
                if (start) begin
                    tile_size_n = cfg_tile_size;
                    n_cin_n     = cfg_n_cin;
                    n_cout_n    = cfg_n_cout;
                    pb_base_n   = cfg_pb_base;
                    cnt_n       = '0;
                    cin_g_n     = '0;
                    cout_g_n    = '0;
                    d_off_n     = '0;
                    p_off_n     = '0;
                    blk_n       = '0;
                    err_n       = 1'b0;
                    state_n     = S_LOADW;
                end
            end
            S_LOADW: begin
                if (w_ack) state_n = S_PRIME;
            end
            S_PRIME: begin
                cnt_n   = '0;
                state_n = S_CALC;
            end
            S_CALC: begin
                // The array's end-of-pass flag must coincide with the final drain cycle.
                if (pe_finish_flg != at_last) err_n = 1'b1;
                if (!at_last) begin
                    cnt_n = cnt + 17'd1;
                end else begin
                    cnt_n = '0;
                    if (cin_g < n_cin) begin
                        cin_g_n = cin_g + 1'b1;
                        d_off_n = d_off + t_step;
                        blk_n   = blk + 1'b1;
                        state_n = S_LOADW;
                    end else if (cout_g < n_cout) begin
                        cin_g_n  = '0;
                        d_off_n  = '0;
                        cout_g_n = cout_g + 1'b1;
                        p_off_n  = p_off + t_step;
                        blk_n    = blk + 1'b1;
                        state_n  = S_LOADW;
                    end else begin
                        state_n = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Registered outputs are derived from the next state so they line up with the state they belong to.
    always_comb begin
        w_req_n    = (state_n == S_LOADW);
        w_addr_n   = blk_n;
        dr_en_n    = 1'b0;
        dr_addr_n  = '0;
        pb_addr_n  = '0;
        new_tile_n = 1'b0;

        if (state_n == S_PRIME) begin
            dr_en_n   = 1'b1;
            dr_addr_n = d_off_n;
        end

        if (state_n == S_CALC) begin
            if (cnt_n < {1'b0, tile_size_n}) begin
                dr_en_n   = 1'b1;
                dr_addr_n = d_off_n + AW'(cnt_n) + AW'(1);
            end
            if (cnt_n <= {1'b0, tile_size_n}) begin
                pb_addr_n  = pb_base_n + p_off_n + AW'(cnt_n);
                new_tile_n = (cin_g_n == '0);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            cin_g     <= '0;
            cout_g    <= '0;
            n_cin     <= '0;
            n_cout    <= '0;
            d_off     <= '0;
            p_off     <= '0;
            blk       <= '0;
            pb_base   <= '0;
            tile_size <= '0;
            err       <= 1'b0;
            w_req     <= 1'b0;
            w_addr    <= '0;
            dr_en     <= 1'b0;
            dr_addr   <= '0;
            pb_addr   <= '0;
            new_tile  <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            cin_g     <= cin_g_n;
            cout_g    <= cout_g_n;
            n_cin     <= n_cin_n;
            n_cout    <= n_cout_n;
            d_off     <= d_off_n;
            p_off     <= p_off_n;
            blk       <= blk_n;
            pb_base   <= pb_base_n;
            tile_size <= tile_size_n;
            err       <= err_n;
            w_req     <= w_req_n;
            w_addr    <= w_addr_n;
            dr_en     <= dr_en_n;
            dr_addr   <= dr_addr_n;
            pb_addr   <= pb_addr_n;
            new_tile  <= new_tile_n;
        end
    end

endmodule

// File: tb/tb_pe_tile_scheduler.sv
// Self-checking bench for pe_tile_scheduler. Expected traffic for each layer is computed
// directly from group indices (block = cout*(n_cin+1)+cin, offsets = index*T).
module tb_pe_tile_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] cfg_tile_size;
    logic [7:0]  cfg_n_cin;
    logic [7:0]  cfg_n_cout;
    logic [15:0] cfg_pb_base;
    logic        w_req;
    logic [15:0] w_addr;
    logic        w_ack;
    logic        dr_en;
    logic [15:0] dr_addr;
    logic [2:0]  top_level_state;
    logic [15:0] pb_addr;
    logic        new_tile;
    logic [15:0] tile_size;
    logic        pe_finish_flg;
    logic        busy;
    logic        done;
    logic        err;

    int total = 0;
    int bad   = 0;
    logic err_model = 1'b0;

    pe_tile_scheduler #(.AW(16), .GW(8)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .cfg_tile_size   (cfg_tile_size),
        .cfg_n_cin       (cfg_n_cin),
        .cfg_n_cout      (cfg_n_cout),
        .cfg_pb_base     (cfg_pb_base),
        .w_req           (w_req),
        .w_addr          (w_addr),
        .w_ack           (w_ack),
        .dr_en           (dr_en),
        .dr_addr         (dr_addr),
        .top_level_state (top_level_state),
        .pb_addr         (pb_addr),
        .new_tile        (new_tile),
        .tile_size       (tile_size),
        .pe_finish_flg   (pe_finish_flg),
        .busy            (busy),
        .done            (done),
        .err             (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Runs one full layer tile; all checks happen at negedge, inputs change there too.
    task automatic run_layer(input int ts, input int ncin, input int ncout, input logic [15:0] base,
                             input int dmin, input int dmax, input int bad_c, input bit poke);
        int          t_len;
        int          dly;
        int          blk;
        logic [15:0] d_off;
        logic [15:0] p_off;
        t_len = ts + 1;
        @(negedge clk);
        check("idle_state", 32'(top_level_state), 32'd0);
        check("err_before_start", 32'(err), 32'(err_model));
        cfg_tile_size = 16'(ts);
        cfg_n_cin     = 8'(ncin);
        cfg_n_cout    = 8'(ncout);
        cfg_pb_base   = base;
        start         = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        err_model = 1'b0;
        check("err_cleared_by_start", 32'(err), 32'(err_model));
        check("tile_size_latched", 32'(tile_size), 32'(ts));
        for (int co = 0; co <= ncout; co++) begin
            for (int ci = 0; ci <= ncin; ci++) begin
                blk   = co * (ncin + 1) + ci;
                d_off = 16'(ci * t_len);
                p_off = 16'(co * t_len);
                check("loadw_state", 32'(top_level_state), 32'd2);
                check("loadw_w_req", 32'(w_req), 32'd1);
                check("loadw_w_addr", 32'(w_addr), 32'(16'(blk)));
                dly = int'($urandom_range(dmax, dmin));
                repeat (dly) begin
                    @(negedge clk);
                    check("stall_state", 32'(top_level_state), 32'd2);
                    check("stall_w_req", 32'(w_req), 32'd1);
                    check("stall_w_addr", 32'(w_addr), 32'(16'(blk)));
                    check("stall_dr_en", 32'(dr_en), 32'd0);
                end
                w_ack = 1'b1;
                @(negedge clk);
                w_ack = 1'b0;
                check("prime_state", 32'(top_level_state), 32'd1);
                check("prime_w_req", 32'(w_req), 32'd0);
                check("prime_dr_en", 32'(dr_en), 32'd1);
                check("prime_dr_addr", 32'(dr_addr), 32'(d_off));
                @(negedge clk);
                for (int c = 0; c <= ts + 3; c++) begin
                    pe_finish_flg = (bad_c >= 0) ? (c == bad_c) : (c == ts + 3);
                    if (poke && c == 1) begin
                        start         = 1'b1;
                        cfg_tile_size = 16'($urandom);
                        cfg_n_cin     = 8'($urandom);
                        cfg_n_cout    = 8'($urandom);
                        cfg_pb_base   = 16'($urandom);
                    end else begin
                        start = 1'b0;
                    end
                    check("calc_state", 32'(top_level_state), 32'd3);
                    check("calc_dr_en", 32'(dr_en), 32'(c < ts));
                    if (c < ts) check("calc_dr_addr", 32'(dr_addr), 32'(16'(d_off + c + 1)));
                    check("calc_pb_addr", 32'(pb_addr), (c <= ts) ? 32'(16'(base + p_off + c)) : 32'd0);
                    check("calc_new_tile", 32'(new_tile), 32'((c <= ts) && (ci == 0)));
                    check("calc_done_low", 32'(done), 32'd0);
                    check("calc_tile_size", 32'(tile_size), 32'(ts));
                    @(negedge clk);
                end
                pe_finish_flg = 1'b0;
                start         = 1'b0;
                if (bad_c >= 0) err_model = 1'b1;
            end
        end
        check("done_state", 32'(top_level_state), 32'd4);
        check("done_pulse", 32'(done), 32'd1);
        check("done_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("after_done_state", 32'(top_level_state), 32'd0);
        check("after_done_pulse", 32'(done), 32'd0);
        check("after_done_busy", 32'(busy), 32'd0);
        check("after_done_err", 32'(err), 32'(err_model));
        check("after_done_tile_size", 32'(tile_size), 32'(ts));
    endtask

    initial begin
        rst           = 1'b1;
        start         = 1'b0;
        w_ack         = 1'b0;
        pe_finish_flg = 1'b0;
        cfg_tile_size = '0;
        cfg_n_cin     = '0;
        cfg_n_cout    = '0;
        cfg_pb_base   = '0;

        // Reset values
        @(negedge clk);
        check("rst_state", 32'(top_level_state), 32'd0);
        check("rst_w_req", 32'(w_req), 32'd0);
        check("rst_w_addr", 32'(w_addr), 32'd0);
        check("rst_dr_en", 32'(dr_en), 32'd0);
        check("rst_pb_addr", 32'(pb_addr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_tile_size", 32'(tile_size), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // T1: assert reset in the middle of CALC
        @(negedge clk);
        cfg_tile_size = 16'd4;
        cfg_n_cin     = 8'd0;
        cfg_n_cout    = 8'd0;
        cfg_pb_base   = 16'h0040;
        start         = 1'b1;
        @(negedge clk);
        start = 1'b0;
        w_ack = 1'b1;
        @(negedge clk);
        w_ack = 1'b0;
        repeat (2) @(negedge clk);
        check("t1_in_calc", 32'(top_level_state), 32'd3);
        rst = 1'b1;
        #1;
        check("t1_async_state", 32'(top_level_state), 32'd0);
        check("t1_async_w_req", 32'(w_req), 32'd0);
        check("t1_async_dr_en", 32'(dr_en), 32'd0);
        check("t1_async_busy", 32'(busy), 32'd0);
        check("t1_async_pb_addr", 32'(pb_addr), 32'd0);
        check("t1_async_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // T2 single group, 2-cycle ack delay
        run_layer(3, 0, 0, 16'h0010, 2, 2, -1, 1'b0);
        // T3 accumulate across cin groups
        run_layer(1, 2, 1, 16'h0000, 0, 1, -1, 1'b0);
        // T4 long handshake stall
        run_layer(2, 0, 0, 16'h0100, 50, 50, -1, 1'b0);
        // T5 early finish flag -> sticky err, cleared by the following start
        run_layer(2, 1, 0, 16'h0020, 0, 1, 4, 1'b0);
        // T6 tile_size=0, start poked during CALC, psum address wrap
        run_layer(0, 1, 1, 16'hFFFF, 0, 2, -1, 1'b1);
        run_layer(3, 0, 2, 16'hFFFE, 0, 1, -1, 1'b0);

        // Randomized layers
        for (int r = 0; r < 6; r++) begin
            run_layer(int'($urandom_range(5, 0)), int'($urandom_range(2, 0)),
                      int'($urandom_range(2, 0)), 16'($urandom), 0, 3, -1, 1'($urandom_range(1, 0)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
